count_sequencer: RTL and testbench

COUNT_SEQUENCER -- requirements
Module: count_sequencer

---
 rtl/count_seq_pkg.sv | 40 ++++
 rtl/btn_debounce.sv | 61 ++++++
 rtl/count_sequencer.sv | 144 ++++++++++++++
 tb/tb_count_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared types and defaults
// for the count sequencer slice.
package count_seq_pkg;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int TICK_DIV_DEF   = 10;
  localparam int PRESC_W        = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    STEP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_CLR,
    EV_RUN,
    EV_STEP
  } evt_e;

  // Resolve same-cycle presses: clr > run > step.
  function automatic evt_e pick_evt(
    input logic clr,
    input logic run,
    input logic step
  );
    evt_e ev;
    ev = EV_NONE;
    if (clr)
      ev = EV_CLR;
    else if (run)
      ev = EV_RUN;
    else if (step)
      ev = EV_STEP;
    return ev;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF sync, stable-count
// debounce and one-cycle rising-edge press.
module btn_debounce
  import count_seq_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic [1:0]    vld;
  logic [CW-1:0] cnt;
  logic          lock;
  logic          deb;
  logic          deb_q;
  logic          cnt_done;
  logic          same;

  assign cnt_done = (cnt == CW'(DEB_CYCLES - 1));
  assign same     = lock && (s2 == deb);

  // First level accepted after reset is adopted
  // silently, so a held button never presses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      vld   <= '0;
      cnt   <= '0;
      lock  <= 1'b0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      press <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      vld   <= {vld[0], 1'b1};
      deb_q <= deb;
      press <= deb & ~deb_q;
      if (!vld[1] || same) begin
        cnt <= '0;
      end else if (cnt_done) begin
        cnt  <= '0;
        deb  <= s2;
        lock <= 1'b1;
        if (!lock)
          deb_q <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: button-driven run/pause/step
// sequencer issuing strobes to a 4-bit counter.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_btn,
  input  logic       step_btn,
  input  logic       clr_btn,
  input  logic       dir_sw,
  input  logic       stop_at_term,
  input  logic [3:0] count,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       cnt_up,
  output logic [1:0] state
);

  logic run_p;
  logic step_p;
  logic clr_p;
  logic dir_s1;
  logic dir_s2;

  state_e             st;
  state_e             st_n;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_n;
  logic               en_n;
  logic               clr_n;
  logic               up_n;
  logic               tick;
  logic               at_term;
  evt_e               ev;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_run (
    .clk  (clk),
    .reset(reset),
    .btn  (run_btn),
    .press(run_p)
  );

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step (
    .clk  (clk),
    .reset(reset),
    .btn  (step_btn),
    .press(step_p)
  );

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_clr (
    .clk  (clk),
    .reset(reset),
    .btn  (clr_btn),
    .press(clr_p)
  );

  assign ev      = pick_evt(clr_p, run_p, step_p);
  assign tick    = (presc == PRESC_W'(TICK_DIV - 1));
  assign at_term = dir_s2 ? (count == 4'hF)
                          : (count == 4'h0);
  assign state   = st;

  // Next state, prescaler and strobes.
  always_comb begin
    st_n    = st;
    presc_n = '0;
    en_n    = 1'b0;
    clr_n   = 1'b0;
    unique case (st)
      IDLE: begin
        case (ev)
          EV_CLR:  clr_n = 1'b1;
          EV_RUN:  st_n  = RUN;
          default: ;
        endcase
      end
      RUN: begin
        case (ev)
          EV_CLR: begin
            st_n  = IDLE;
            clr_n = 1'b1;
          end
          EV_RUN: st_n = PAUSE;
          default: begin
            if (!tick)
              presc_n = presc + 1'b1;
            else if (stop_at_term && at_term)
              st_n = PAUSE;
            else
              en_n = 1'b1;
          end
        endcase
      end
      PAUSE: begin
        case (ev)
          EV_CLR: begin
            st_n  = IDLE;
            clr_n = 1'b1;
          end
          EV_RUN: st_n = RUN;
          EV_STEP: begin
            st_n = STEP;
            en_n = 1'b1;
          end
          default: ;
        endcase
      end
      STEP: st_n = PAUSE;
    endcase
    up_n = en_n ? dir_s2 : cnt_up;
  end

  // State, prescaler, dir sync and output regs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st      <= IDLE;
      presc   <= '0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      cnt_up  <= 1'b1;
      dir_s1  <= 1'b0;
      dir_s2  <= 1'b0;
    end else begin
      st      <= st_n;
      presc   <= presc_n;
      cnt_en  <= en_n;
      cnt_clr <= clr_n;
      cnt_up  <= up_n;
      dir_s1  <= dir_sw;
      dir_s2  <= dir_s1;
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: scoreboard bench with
// directed button scripts on absolute edges.
module tb_count_sequencer;

  localparam int DEB  = 2;
  localparam int TDIV = 4;

  logic       clk          = 1'b0;
  logic       reset        = 1'b0;
  logic       run_btn      = 1'b0;
  logic       step_btn     = 1'b0;
  logic       clr_btn      = 1'b0;
  logic       dir_sw       = 1'b1;
  logic       stop_at_term = 1'b0;
  logic [3:0] count        = 4'h0;
  logic       cnt_en;
  logic       cnt_clr;
  logic       cnt_up;
  logic [1:0] state;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         e;
    logic [1:0] st;
    logic       en;
    logic       clr;
    logic       up;
  } exp_t;

  exp_t sb[$];
  logic [1:0] prev_st = 2'd0;

  count_sequencer #(
    .DEB_CYCLES(DEB),
    .TICK_DIV  (TDIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run_btn     (run_btn),
    .step_btn    (step_btn),
    .clr_btn     (clr_btn),
    .dir_sw      (dir_sw),
    .stop_at_term(stop_at_term),
    .count       (count),
    .cnt_en      (cnt_en),
    .cnt_clr     (cnt_clr),
    .cnt_up      (cnt_up),
    .state       (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void ex(
    input int         e,
    input logic [1:0] st,
    input logic       en,
    input logic       clr,
    input logic       up
  );
    exp_t x;
    x.e   = e;
    x.st  = st;
    x.en  = en;
    x.clr = clr;
    x.up  = up;
    sb.push_back(x);
  endfunction

  // Wait so the next drive is sampled at edge e.
  task automatic at(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  task automatic chk(
    input string nm,
    input logic  got,
    input logic  req
  );
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", nm, got, req);
    end
  endtask

  // Monitor: any strobe or state change pops one
  // expected event and must match it exactly.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (cnt_en === 1'b1 || cnt_clr === 1'b1 ||
        state !== prev_st) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d st=%0d en=%b clr=%b",
                 cyc, state, cnt_en, cnt_clr);
      end else begin
        x = sb.pop_front();
        if (cyc != x.e || state !== x.st ||
            cnt_en !== x.en || cnt_clr !== x.clr ||
            (x.en && cnt_up !== x.up)) begin
          failures++;
          $display({"FAIL event got cyc=%0d st=%0d en=%b",
                    " clr=%b up=%b exp cyc=%0d st=%0d",
                    " en=%b clr=%b up=%b"},
                   cyc, state, cnt_en, cnt_clr, cnt_up,
                   x.e, x.st, x.en, x.clr, x.up);
        end
      end
    end
    prev_st = state;
  end

  initial begin
    // run press with bounce, ticks, press beats tick
    ex(67,  2'd1, 1'b0, 1'b0, 1'b1);
    ex(71,  2'd1, 1'b1, 1'b0, 1'b1);
    ex(75,  2'd1, 1'b1, 1'b0, 1'b1);
    ex(79,  2'd1, 1'b1, 1'b0, 1'b1);
    ex(83,  2'd2, 1'b0, 1'b0, 1'b1);
    // steps from PAUSE, incl. at 4'hF and down
    ex(101, 2'd3, 1'b1, 1'b0, 1'b1);
    ex(102, 2'd2, 1'b0, 1'b0, 1'b1);
    ex(111, 2'd3, 1'b1, 1'b0, 1'b1);
    ex(112, 2'd2, 1'b0, 1'b0, 1'b1);
    ex(121, 2'd3, 1'b1, 1'b0, 1'b0);
    ex(122, 2'd2, 1'b0, 1'b0, 1'b1);
    // stop at terminal count
    ex(135, 2'd1, 1'b0, 1'b0, 1'b1);
    ex(139, 2'd1, 1'b1, 1'b0, 1'b1);
    ex(143, 2'd2, 1'b0, 1'b0, 1'b1);
    // wrap mode, then all three pressed at once
    ex(155, 2'd1, 1'b0, 1'b0, 1'b1);
    ex(159, 2'd1, 1'b1, 1'b0, 1'b1);
    ex(163, 2'd1, 1'b1, 1'b0, 1'b1);
    ex(167, 2'd1, 1'b1, 1'b0, 1'b1);
    ex(170, 2'd0, 1'b0, 1'b1, 1'b1);
    // clr in IDLE
    ex(181, 2'd0, 1'b0, 1'b1, 1'b1);
    // reset mid-RUN with run held
    ex(201, 2'd1, 1'b0, 1'b0, 1'b1);
    ex(205, 2'd1, 1'b1, 1'b0, 1'b1);
    ex(209, 2'd1, 1'b1, 1'b0, 1'b1);
    ex(211, 2'd0, 1'b0, 1'b0, 1'b1);
    // re-press after release, clr beats tick
    ex(255, 2'd1, 1'b0, 1'b0, 1'b1);
    ex(259, 2'd1, 1'b1, 1'b0, 1'b1);
    ex(263, 2'd1, 1'b1, 1'b0, 1'b1);
    ex(267, 2'd0, 1'b0, 1'b1, 1'b1);

    at(4);
    chk("rst_state0", state[0], 1'b0);
    chk("rst_state1", state[1], 1'b0);
    chk("rst_cnt_en", cnt_en, 1'b0);
    chk("rst_cnt_clr", cnt_clr, 1'b0);
    chk("rst_cnt_up", cnt_up, 1'b1);
    reset = 1'b1;

    at(60);  run_btn = 1'b1;
    at(61);  run_btn = 1'b0;
    at(62);  run_btn = 1'b1;
    at(72);  run_btn = 1'b0;
    at(78);  run_btn = 1'b1;
    at(90);  run_btn = 1'b0;

    at(96);  step_btn = 1'b1;
    at(100); step_btn = 1'b0;
    at(104); count = 4'hF; stop_at_term = 1'b1;
    at(106); step_btn = 1'b1;
    at(110); step_btn = 1'b0;
    at(114); dir_sw = 1'b0;
    at(116); step_btn = 1'b1;
    at(120); step_btn = 1'b0;
    at(124); dir_sw = 1'b1;

    at(125); count = 4'hE;
    at(130); run_btn = 1'b1;
    at(134); run_btn = 1'b0;
    at(141); count = 4'hF;

    at(145); stop_at_term = 1'b0;
    at(150); run_btn = 1'b1;
    at(154); run_btn = 1'b0;
    at(165);
    run_btn  = 1'b1;
    step_btn = 1'b1;
    clr_btn  = 1'b1;
    at(169);
    run_btn  = 1'b0;
    step_btn = 1'b0;
    clr_btn  = 1'b0;

    at(176); clr_btn = 1'b1;
    at(180); clr_btn = 1'b0;
    at(186); step_btn = 1'b1;
    at(190); step_btn = 1'b0;

    at(195); count = 4'h3;
    at(196); run_btn = 1'b1;
    at(211); reset = 1'b0;
    at(212); reset = 1'b1;
    at(240); run_btn = 1'b0;
    at(250); run_btn = 1'b1;
    at(254); run_btn = 1'b0;
    at(262); clr_btn = 1'b1;
    at(266); clr_btn = 1'b0;

    at(290);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL missing_events left=%0d exp=0",
               sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
